// File: rtl/cpe_pkg.sv
// Shared definitions for the cpe core: data widths, reset PC default and the
// instruction-fetch FSM encoding.
package cpe_pkg;
  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [ILEN-1:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/cpe_ifetch_if.sv
// Fetch-stage bundle: redirect input, instruction-memory bus, decode handshake
// and FSM debug state. master = fetch stage, slave = surrounding core/memory.
interface cpe_ifetch_if;
  import cpe_pkg::*;

  // imem: req is held until gnt with addr stable; rvalid returns in request order.
  // decode: instr/pc transfer on a cycle where instr_vld and instr_rdy are both 1.
  logic            redir_w_i_h;
  logic [XLEN-1:0] redir_pc_w_i;
  logic            imem_req_w_o_h;
  logic [XLEN-1:0] imem_addr_w_o;
  logic            imem_gnt_w_i_h;
  logic            imem_rvalid_w_i_h;
  logic [ILEN-1:0] imem_rdata_w_i;
  logic [ILEN-1:0] instr_w_o;
  logic [XLEN-1:0] pc_w_o;
  logic            instr_vld_w_o_h;
  logic            instr_rdy_w_i_h;
  logic            misalign_w_o_h;
  fetch_state_e    state;

  modport master (
    input  redir_w_i_h, redir_pc_w_i, imem_gnt_w_i_h, imem_rvalid_w_i_h,
           imem_rdata_w_i, instr_rdy_w_i_h,
    output imem_req_w_o_h, imem_addr_w_o, instr_w_o, pc_w_o, instr_vld_w_o_h,
           misalign_w_o_h, state
  );

  modport slave (
    output redir_w_i_h, redir_pc_w_i, imem_gnt_w_i_h, imem_rvalid_w_i_h,
           imem_rdata_w_i, instr_rdy_w_i_h,
    input  imem_req_w_o_h, imem_addr_w_o, instr_w_o, pc_w_o, instr_vld_w_o_h,
           misalign_w_o_h, state
  );
endinterface

// File: rtl/cpe_sync_fifo.sv
// Small synchronous FIFO with first-word fall-through read, flush and an
// occupancy count. DEPTH must be a power of two.
module cpe_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic [CW-1:0]    cnt
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push, do_pop;

  assign do_pop  = pop && (count != '0);
  // A full FIFO still accepts a push in the cycle its head is popped.
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign empty = (count == '0);
  assign cnt   = count;
endmodule

// File: rtl/cpe_ifetch.sv
// Instruction fetch stage: sequential word fetch over req/gnt/rvalid with a
// credit-limited buffer, redirect handling and misaligned-target halt.
module cpe_ifetch
  import cpe_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEF,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic         clk_w_i,
  input  logic         res_w_i_h,
  cpe_ifetch_if.master bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int FW = XLEN + ILEN;

  fetch_state_e    state, state_nxt;
  logic [XLEN-1:0] fetch_pc, resp_pc;
  logic [CW-1:0]   outstanding, drop, fifo_cnt;
  logic            req, fire, push, pop, fifo_empty, misalign_q, redir_mis;
  logic [FW-1:0]   fifo_rdata;

  assign redir_mis = bus.redir_w_i_h && (bus.redir_pc_w_i[1:0] != 2'b00);

  always_ff @(posedge clk_w_i or posedge res_w_i_h) begin
    if (res_w_i_h) state <= RUN;
    else           state <= state_nxt;
  end

  // Credit counts buffered words plus in-flight reads (dropped ones included),
  // so a returning word always has a free FIFO slot.
  always_comb begin
    state_nxt = state;
    req       = 1'b0;
    if (bus.redir_w_i_h) state_nxt = redir_mis ? HALT : RUN;
    if (!res_w_i_h && (state == RUN) && !bus.redir_w_i_h &&
        ((fifo_cnt + outstanding) < CW'(FIFO_DEPTH)))
      req = 1'b1;
  end

  assign fire = req && bus.imem_gnt_w_i_h;
  assign push = bus.imem_rvalid_w_i_h && !bus.redir_w_i_h && (drop == '0);
  assign pop  = !fifo_empty && bus.instr_rdy_w_i_h;

  always_ff @(posedge clk_w_i or posedge res_w_i_h) begin
    if (res_w_i_h) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
      misalign_q  <= 1'b0;
    end else begin
      outstanding <= outstanding + CW'(fire) - CW'(bus.imem_rvalid_w_i_h);
      misalign_q  <= redir_mis;
      if (bus.redir_w_i_h) begin
        fetch_pc <= word_align(bus.redir_pc_w_i);
        resp_pc  <= word_align(bus.redir_pc_w_i);
        drop     <= outstanding - CW'(bus.imem_rvalid_w_i_h);
      end else begin
        if (fire) fetch_pc <= fetch_pc + 32'd4;
        if (push) resp_pc  <= resp_pc + 32'd4;
        if (bus.imem_rvalid_w_i_h && (drop != '0)) drop <= drop - CW'(1);
      end
    end
  end

  cpe_sync_fifo #(
    .WIDTH(FW),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_w_i),
    .rst   (res_w_i_h),
    .push  (push),
    .wdata ({resp_pc, bus.imem_rdata_w_i}),
    .pop   (pop),
    .flush (bus.redir_w_i_h),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .cnt   (fifo_cnt)
  );

  assign bus.imem_req_w_o_h  = req;
  assign bus.imem_addr_w_o   = fetch_pc;
  assign bus.instr_vld_w_o_h = !fifo_empty;
  assign bus.instr_w_o       = fifo_empty ? '0 : fifo_rdata[ILEN-1:0];
  assign bus.pc_w_o          = fifo_empty ? resp_pc : fifo_rdata[FW-1:ILEN];
  assign bus.misalign_w_o_h  = misalign_q;
  assign bus.state           = state;
endmodule

// File: tb/tb_cpe_ifetch.sv
// Bench for cpe_ifetch: memory responder, in-order instruction scoreboard,
// redirect vector table and hand-written stall/drop/reset sequences.
module tb_cpe_ifetch;
  import cpe_pkg::*;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rv_en;
  always #5 clk = ~clk;

  cpe_ifetch_if bus();

  cpe_ifetch #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk_w_i   (clk),
    .res_w_i_h (rst),
    .bus       (bus)
  );

  logic [63:0] exp_q[$];
  logic [31:0] pend_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int pops  = 0;

  typedef struct {
    logic [31:0] target;
    logic        exp_mis;
  } vec_t;
  vec_t vecs[6];

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input int n);
    repeat (n) sync();
  endtask

  task automatic load_stream(input logic [31:0] base);
    logic [31:0] p;
    exp_q.delete();
    for (int k = 0; k < 100; k++) begin
      p = base + 32'(4 * k);
      exp_q.push_back({p, mdata(p)});
    end
  endtask

  task automatic redirect(input logic [31:0] t);
    bus.redir_w_i_h  = 1'b1;
    bus.redir_pc_w_i = t;
    @(negedge clk);
    check("redir_req_masked", 64'(bus.imem_req_w_o_h), 64'd0);
    sync();
    bus.redir_w_i_h = 1'b0;
    if (t[1:0] == 2'b00) load_stream(t);
    else exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},      64'(bus.imem_req_w_o_h),  64'd0);
    check({tag, "_addr"},     64'(bus.imem_addr_w_o),   64'(RST_PC));
    check({tag, "_vld"},      64'(bus.instr_vld_w_o_h), 64'd0);
    check({tag, "_instr"},    64'(bus.instr_w_o),       64'd0);
    check({tag, "_pc"},       64'(bus.pc_w_o),          64'(RST_PC));
    check({tag, "_misalign"}, 64'(bus.misalign_w_o_h),  64'd0);
    check({tag, "_state"},    64'(bus.state),           64'(RUN));
  endtask

  // Memory responder: one response per cycle, in grant order, gated by rv_en.
  initial begin
    logic        hs;
    logic [31:0] a;
    bus.imem_rvalid_w_i_h = 1'b0;
    bus.imem_rdata_w_i    = '0;
    forever begin
      @(negedge clk);
      hs = bus.imem_req_w_o_h && bus.imem_gnt_w_i_h;
      a  = bus.imem_addr_w_o;
      @(posedge clk);
      #2;
      if (rst) pend_q.delete();
      else begin
        if (bus.imem_rvalid_w_i_h) void'(pend_q.pop_front());
        if (hs) pend_q.push_back(a);
      end
      if (!rst && rv_en && pend_q.size() != 0) begin
        bus.imem_rvalid_w_i_h = 1'b1;
        bus.imem_rdata_w_i    = mdata(pend_q[0]);
      end else begin
        bus.imem_rvalid_w_i_h = 1'b0;
        bus.imem_rdata_w_i    = '0;
      end
    end
  end

  // Scoreboard: every accepted instruction must match the head of exp_q.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && bus.instr_vld_w_o_h && bus.instr_rdy_w_i_h) begin
        pops++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL extra_instr: got pc %h instr %h, expected no instruction",
                   bus.pc_w_o, bus.instr_w_o);
        end else begin
          check("instr_stream", {bus.pc_w_o, bus.instr_w_o}, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    int          p0;
    bit          found;
    logic [63:0] head;

    vecs[0] = '{32'h0000_0102, 1'b1};
    vecs[1] = '{32'h0000_0200, 1'b0};
    vecs[2] = '{32'hFFFF_FFFC, 1'b0};
    vecs[3] = '{32'h0000_0041, 1'b1};
    vecs[4] = '{32'h0000_0803, 1'b1};
    vecs[5] = '{32'h0000_1000, 1'b0};

    bus.redir_w_i_h     = 1'b0;
    bus.redir_pc_w_i    = '0;
    bus.imem_gnt_w_i_h  = 1'b0;
    bus.instr_rdy_w_i_h = 1'b0;
    rv_en               = 1'b1;

    sync();
    check_reset_outputs("reset");
    tick(2);
    rst = 1'b0;
    bus.imem_gnt_w_i_h  = 1'b1;
    bus.instr_rdy_w_i_h = 1'b1;
    load_stream(RST_PC);
    @(negedge clk);
    check("first_req",  64'(bus.imem_req_w_o_h), 64'd1);
    check("first_addr", 64'(bus.imem_addr_w_o),  64'(RST_PC));

    // Sustained stream: one instruction per cycle once the pipe is full.
    tick(5);
    p0 = pops;
    tick(12);
    check("throughput", 64'(pops - p0), 64'd12);

    // Decode stall: head holds, buffer fills, requests stop.
    bus.instr_rdy_w_i_h = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      head = exp_q[0];
      check("stall_head", {bus.pc_w_o, bus.instr_w_o}, head);
      check("stall_vld", 64'(bus.instr_vld_w_o_h), 64'd1);
      if (c >= 5) check("stall_req", 64'(bus.imem_req_w_o_h), 64'd0);
    end
    sync();
    bus.imem_gnt_w_i_h  = 1'b0;
    bus.instr_rdy_w_i_h = 1'b1;
    p0 = pops;
    tick(8);
    check("drain_count", 64'(pops - p0), 64'(DEPTH));
    @(negedge clk);
    head = exp_q[0];
    check("drain_vld",  64'(bus.instr_vld_w_o_h), 64'd0);
    check("drain_req",  64'(bus.imem_req_w_o_h),  64'd1);
    check("drain_addr", 64'(bus.imem_addr_w_o),   64'(head[63:32]));
    sync();
    bus.imem_gnt_w_i_h = 1'b1;
    tick(10);
    check("resume", 64'(pops - p0 >= DEPTH + 5), 64'd1);

    // Two granted reads left in flight across a redirect are discarded.
    bus.imem_gnt_w_i_h = 1'b0;
    rv_en = 1'b0;
    redirect(32'h0000_0040);
    bus.imem_gnt_w_i_h = 1'b1;
    tick(2);
    bus.imem_gnt_w_i_h = 1'b0;
    redirect(32'h0000_0100);
    @(negedge clk);
    check("flushed_vld", 64'(bus.instr_vld_w_o_h), 64'd0);
    sync();
    rv_en = 1'b1;
    bus.imem_gnt_w_i_h = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (bus.instr_vld_w_o_h) begin
        found = 1'b1;
        check("after_drop_pc",    64'(bus.pc_w_o),    64'h100);
        check("after_drop_instr", 64'(bus.instr_w_o), 64'(mdata(32'h100)));
      end
    end
    if (!found) begin
      n_cmp++;
      n_err++;
      $display("FAIL after_drop_timeout: got no instr_vld in 20 cycles, expected pc 00000100");
    end
    sync();
    tick(4);

    // Redirect vector table: aligned targets restart fetch, misaligned halt.
    for (int i = 0; i < 6; i++) begin
      redirect(vecs[i].target);
      @(negedge clk);
      check("vec_misalign", 64'(bus.misalign_w_o_h), 64'(vecs[i].exp_mis));
      check("vec_state",    64'(bus.state),          vecs[i].exp_mis ? 64'(HALT) : 64'(RUN));
      check("vec_req",      64'(bus.imem_req_w_o_h), 64'(!vecs[i].exp_mis));
      if (!vecs[i].exp_mis)
        check("vec_addr", 64'(bus.imem_addr_w_o), 64'(vecs[i].target));
      p0 = pops;
      @(negedge clk);
      check("vec_misalign_pulse", 64'(bus.misalign_w_o_h), 64'd0);
      sync();
      tick(10);
      @(negedge clk);
      if (vecs[i].exp_mis) begin
        check("halt_pops", 64'(pops - p0), 64'd0);
        check("halt_req",  64'(bus.imem_req_w_o_h), 64'd0);
      end else begin
        check("run_pops", 64'(pops - p0 >= 6), 64'd1);
      end
      sync();
    end

    // Asynchronous reset in the middle of a stream.
    #3;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    tick(2);
    rst = 1'b0;
    load_stream(RST_PC);
    p0 = pops;
    @(negedge clk);
    check("post_reset_req",  64'(bus.imem_req_w_o_h), 64'd1);
    check("post_reset_addr", 64'(bus.imem_addr_w_o),  64'(RST_PC));
    sync();
    tick(10);
    check("post_reset_pops", 64'(pops - p0 >= 6), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
